// File: rtl/apb_regs_pkg.sv
// Shared definitions for the APB config/status register bank.
// Holds the register byte offsets, the bit positions inside CTRL and
// STATUS, and a helper that reduces a byte address to a word index.
package apb_regs_pkg;

  localparam logic [11:0] ADDR_CTRL    = 12'h000;
  localparam logic [11:0] ADDR_LOAD    = 12'h004;
  localparam logic [11:0] ADDR_COUNT   = 12'h008;
  localparam logic [11:0] ADDR_STATUS  = 12'h00C;
  localparam logic [11:0] ADDR_INT_EN  = 12'h010;
  localparam logic [11:0] ADDR_EVT_CNT = 12'h014;
  localparam logic [11:0] ADDR_SCRATCH = 12'h018;
  localparam logic [11:0] ADDR_ID      = 12'h01C;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;

  localparam int ST_EXPIRED = 0;
  localparam int ST_EVENT   = 1;
  localparam int ST_EVT_OVF = 2;

  // Registers are word-wide; the byte-lane bits of an address are ignored.
  function automatic logic [9:0] word_of(input logic [11:0] addr);
    return addr[11:2];
  endfunction

endpackage

// File: rtl/apb_reg_timer.sv
// Reloadable down-counter timer for the register bank.
// Ports:
//   PCLK, PRESETn     clock and asynchronous active-low reset
//   ctrl_we           CTRL register write strobe
//   ctrl_wdata[1:0]   {AUTO_RELOAD, EN} written to CTRL
//   load_we           LOAD register write strobe
//   load_wdata        value written to LOAD (also loaded into COUNT)
//   en, auto_reload   current CTRL bits
//   load, count       current LOAD and COUNT registers
//   expire            combinational: this edge is an expiry edge
//   timer_tick        registered one-cycle pulse following an expiry edge
module apb_reg_timer
  import apb_regs_pkg::*;
#(
  parameter logic [31:0] RESET_LOAD = 32'h0000_FFFF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        ctrl_we,
  input  logic [1:0]  ctrl_wdata,
  input  logic        load_we,
  input  logic [31:0] load_wdata,
  output logic        en,
  output logic        auto_reload,
  output logic [31:0] load,
  output logic [31:0] count,
  output logic        expire,
  output logic        timer_tick
);

  assign expire = en && (count == 32'h0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      load        <= RESET_LOAD;
      count       <= RESET_LOAD;
      timer_tick  <= 1'b0;
    end else begin
      timer_tick <= expire;

      // A CTRL write overrides the one-shot self-clear of EN.
      if (ctrl_we) begin
        en          <= ctrl_wdata[CTRL_EN];
        auto_reload <= ctrl_wdata[CTRL_AUTO];
      end else if (expire && !auto_reload) begin
        en <= 1'b0;
      end

      if (load_we) begin
        load <= load_wdata;
      end

      // COUNT priority: LOAD write, then start (EN 0->1), then expiry, then decrement.
      if (load_we) begin
        count <= load_wdata;
      end else if (ctrl_we && ctrl_wdata[CTRL_EN] && !en) begin
        count <= load;
      end else if (expire) begin
        count <= auto_reload ? load : 32'h0;
      end else if (en) begin
        count <= count - 32'd1;
      end
    end
  end

endmodule

// File: rtl/apb_cfg_status_regs.sv
// Config/status register bank behind the APB slave stage.
// Bus side: wen/ren are single-cycle strobes raised by the upstream stage in
// the APB access phase; there is no ready/wait - every write commits on the
// PCLK edge where wen is high, and rdata is a pure combinational function of
// raddr and register state, valid whether or not ren is high. ren only matters
// for the clear-on-read side effect of EVT_CNT. wen and ren may coincide and
// are processed independently.
// Ports:
//   PCLK, PRESETn   clock and asynchronous active-low reset
//   wen/waddr/wdata write strobe, byte address, data
//   ren/raddr       read strobe and byte address
//   rdata           combinational read data
//   event_in        external event level (synchronous to PCLK)
//   irq             registered |(STATUS & INT_EN), one cycle late
//   timer_tick      one-cycle pulse after each timer expiry
module apb_cfg_status_regs
  import apb_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = 32'h0A4B_0001,
  parameter logic [31:0] RESET_LOAD = 32'h0000_FFFF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        wen,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  input  logic        event_in,
  output logic        irq,
  output logic        timer_tick
);

  logic [9:0]  w_word;
  logic [9:0]  r_word;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic        wr_int_en;
  logic        wr_scratch;
  logic        rd_evt_cnt;

  logic        tmr_en;
  logic        tmr_auto;
  logic        tmr_expire;
  logic [31:0] tmr_load;
  logic [31:0] tmr_count;

  logic        event_q;
  logic        evt_edge;
  logic        evt_sat;
  logic [15:0] evt_cnt;
  logic [15:0] evt_cnt_nxt;
  logic [2:0]  status;
  logic [2:0]  status_set;
  logic [2:0]  status_clr;
  logic [2:0]  status_nxt;
  logic [2:0]  int_en;
  logic [31:0] scratch;

  assign w_word = word_of(waddr);
  assign r_word = word_of(raddr);

  assign wr_ctrl    = wen && (w_word == ADDR_CTRL[11:2]);
  assign wr_load    = wen && (w_word == ADDR_LOAD[11:2]);
  assign wr_status  = wen && (w_word == ADDR_STATUS[11:2]);
  assign wr_int_en  = wen && (w_word == ADDR_INT_EN[11:2]);
  assign wr_scratch = wen && (w_word == ADDR_SCRATCH[11:2]);
  assign rd_evt_cnt = ren && (r_word == ADDR_EVT_CNT[11:2]);

  apb_reg_timer #(
    .RESET_LOAD (RESET_LOAD)
  ) u_timer (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .ctrl_we     (wr_ctrl),
    .ctrl_wdata  (wdata[1:0]),
    .load_we     (wr_load),
    .load_wdata  (wdata),
    .en          (tmr_en),
    .auto_reload (tmr_auto),
    .load        (tmr_load),
    .count       (tmr_count),
    .expire      (tmr_expire),
    .timer_tick  (timer_tick)
  );

  assign evt_edge = event_in & ~event_q;
  assign evt_sat  = (evt_cnt == 16'hFFFF);

  // Clear-on-read restarts the count; an edge in the same cycle is kept as 1.
  always_comb begin
    evt_cnt_nxt = evt_cnt;
    if (rd_evt_cnt) begin
      evt_cnt_nxt = evt_edge ? 16'd1 : 16'd0;
    end else if (evt_edge && !evt_sat) begin
      evt_cnt_nxt = evt_cnt + 16'd1;
    end
  end

  // Hardware sets are OR-ed in after the W1C mask so a same-cycle set wins.
  always_comb begin
    status_set             = 3'b000;
    status_set[ST_EXPIRED] = tmr_expire;
    status_set[ST_EVENT]   = evt_edge;
    status_set[ST_EVT_OVF] = evt_edge && evt_sat;
    status_clr             = wr_status ? wdata[2:0] : 3'b000;
    status_nxt             = (status & ~status_clr) | status_set;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      event_q <= 1'b0;
      evt_cnt <= 16'h0;
      status  <= 3'b000;
      int_en  <= 3'b000;
      scratch <= 32'h0;
      irq     <= 1'b0;
    end else begin
      event_q <= event_in;
      evt_cnt <= evt_cnt_nxt;
      status  <= status_nxt;
      irq     <= |(status & int_en);
      if (wr_int_en) begin
        int_en <= wdata[2:0];
      end
      if (wr_scratch) begin
        scratch <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (r_word)
      ADDR_CTRL[11:2]: begin
        rdata[CTRL_EN]   = tmr_en;
        rdata[CTRL_AUTO] = tmr_auto;
      end
      ADDR_LOAD[11:2]:    rdata = tmr_load;
      ADDR_COUNT[11:2]:   rdata = tmr_count;
      ADDR_STATUS[11:2]:  rdata[2:0] = status;
      ADDR_INT_EN[11:2]:  rdata[2:0] = int_en;
      ADDR_EVT_CNT[11:2]: rdata[15:0] = evt_cnt;
      ADDR_SCRATCH[11:2]: rdata = scratch;
      ADDR_ID[11:2]:      rdata = ID_VALUE;
      default:            rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_apb_cfg_status_regs.sv
// Self-checking bench for apb_cfg_status_regs.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 4 time units after the rising edge, before the next edge commits anything.
module tb_apb_cfg_status_regs;
  import apb_regs_pkg::*;

  localparam logic [31:0] EXP_ID   = 32'h0A4B_0001;
  localparam logic [31:0] EXP_LOAD = 32'h0000_FFFF;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        wen = 1'b0;
  logic [11:0] waddr = 12'h0;
  logic [31:0] wdata = 32'h0;
  logic        ren = 1'b0;
  logic [11:0] raddr = 12'h0;
  logic [31:0] rdata;
  logic        event_in = 1'b0;
  logic        irq;
  logic        timer_tick;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic        s_irq;
  logic        s_tick;

  apb_cfg_status_regs dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .ren        (ren),
    .raddr      (raddr),
    .rdata      (rdata),
    .event_in   (event_in),
    .irq        (irq),
    .timer_tick (timer_tick)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit (tests run %0d)", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at the following posedge+1.
  task automatic do_cycle(input logic w, input logic [11:0] wa, input logic [31:0] wd,
                          input logic r, input logic [11:0] ra, output logic [31:0] rd);
    wen = w; waddr = wa; wdata = wd; ren = r; raddr = ra;
    #3;
    rd     = rdata;
    s_irq  = irq;
    s_tick = timer_tick;
    @(posedge PCLK);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    do_cycle(1'b1, a, d, 1'b0, 12'h0, unused_rd);
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] rd);
    do_cycle(1'b0, 12'h0, 32'h0, 1'b1, a, rd);
  endtask

  task automatic bus_peek(input logic [11:0] a, output logic [31:0] rd);
    do_cycle(1'b0, 12'h0, 32'h0, 1'b0, a, rd);
  endtask

  task automatic idle();
    logic [31:0] unused_rd;
    bus_peek(12'h0, unused_rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] a_tab[9];
    logic [31:0] e_tab[9];
    logic [31:0] obs;
    logic [31:0] e;
    a_tab = '{ADDR_CTRL, ADDR_LOAD, ADDR_COUNT, ADDR_STATUS, ADDR_INT_EN,
              ADDR_EVT_CNT, ADDR_SCRATCH, ADDR_ID, 12'h020};
    e_tab = '{32'h0, EXP_LOAD, EXP_LOAD, 32'h0, 32'h0, 32'h0, 32'h0, EXP_ID, 32'h0};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(e_tab[i]);
      bus_read(a_tab[i], obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL reset_read[%03h]: got %08h want %08h", a_tab[i], obs, e);
      end
    end
    tests_run++;
    if (s_irq !== 1'b0 || s_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: irq=%b tick=%b want 0 0", s_irq, s_tick);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a_tab[6];
    logic [31:0] e_tab[6];
    logic [31:0] obs;
    logic [31:0] e;
    // Write and read SCRATCH in one cycle: read sees the old value.
    exp_q.push_back(32'h0);
    do_cycle(1'b1, ADDR_SCRATCH, 32'hA5A5_5A5A, 1'b1, ADDR_SCRATCH, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL wr_rd_same_cycle: got %08h want %08h", obs, e);
    end
    bus_write(12'h020, 32'hDEAD_BEEF);
    bus_write(ADDR_CTRL, 32'hFFFF_FFFC);
    bus_write(ADDR_INT_EN, 32'hFFFF_FFFF);
    a_tab = '{ADDR_SCRATCH, 12'h020, ADDR_CTRL, ADDR_INT_EN, ADDR_SCRATCH, ADDR_INT_EN};
    e_tab = '{32'hA5A5_5A5A, 32'h0, 32'h0, 32'h7, 32'h0000_0011, 32'h0};
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus_write(12'h01B, 32'h0000_0011);
      if (i == 5) bus_write(ADDR_INT_EN, 32'h0);
      exp_q.push_back(e_tab[i]);
      bus_peek(a_tab[i], obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL b2b_read%0d[%03h]: got %08h want %08h", i, a_tab[i], obs, e);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] obs;
    logic [31:0] e;
    bus_write(ADDR_LOAD, 32'd5);
    bus_write(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back((i < 6) ? 32'(5 - i) : 32'h0);
      exp_q.push_back({31'h0, (i == 6)});
      bus_read(ADDR_COUNT, obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL oneshot_count[%0d]: got %08h want %08h", i, obs, e);
      end
      e = exp_q.pop_front();
      tests_run++;
      if ({31'h0, s_tick} !== e) begin
        tests_failed++;
        $display("FAIL oneshot_tick[%0d]: got %b want %b", i, s_tick, e[0]);
      end
    end
    exp_q.push_back(32'h1);
    bus_peek(ADDR_STATUS, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL oneshot_status: got %08h want %08h", obs, e);
    end
    exp_q.push_back(32'h0);
    bus_peek(ADDR_CTRL, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL oneshot_ctrl: got %08h want %08h", obs, e);
    end
    bus_write(ADDR_STATUS, 32'h1);
  endtask

  task automatic test_load_zero();
    logic [31:0] obs;
    logic [31:0] e;
    bus_write(ADDR_LOAD, 32'h0);
    bus_write(ADDR_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({31'h0, (i >= 1)});
      bus_peek(ADDR_COUNT, obs);
      e = exp_q.pop_front();
      tests_run++;
      if ({31'h0, s_tick} !== e || obs !== 32'h0) begin
        tests_failed++;
        $display("FAIL load0_tick[%0d]: got tick=%b count=%08h want tick=%b count=0", i, s_tick, obs, e[0]);
      end
    end
    bus_write(ADDR_CTRL, 32'h0);
    idle();
    bus_write(ADDR_STATUS, 32'h7);
  endtask

  task automatic test_auto_reload();
    logic [31:0] obs;
    logic [31:0] e;
    bus_write(ADDR_STATUS, 32'h7);
    bus_write(ADDR_INT_EN, 32'h1);
    bus_write(ADDR_LOAD, 32'd3);
    bus_write(ADDR_CTRL, 32'h3);
    for (int c = 0; c < 13; c++) begin
      exp_q.push_back(32'(3 - (c % 4)));
      exp_q.push_back({31'h0, (c >= 4 && (c % 4) == 0)});
      exp_q.push_back({31'h0, (c >= 5 && c != 8)});
      if (c == 6) do_cycle(1'b1, ADDR_STATUS, 32'h1, 1'b1, ADDR_COUNT, obs);
      else        bus_read(ADDR_COUNT, obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL auto_count[%0d]: got %08h want %08h", c, obs, e);
      end
      e = exp_q.pop_front();
      tests_run++;
      if ({31'h0, s_tick} !== e) begin
        tests_failed++;
        $display("FAIL auto_tick[%0d]: got %b want %b", c, s_tick, e[0]);
      end
      e = exp_q.pop_front();
      tests_run++;
      if ({31'h0, s_irq} !== e) begin
        tests_failed++;
        $display("FAIL auto_irq[%0d]: got %b want %b", c, s_irq, e[0]);
      end
    end
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_INT_EN, 32'h0);
    bus_write(ADDR_STATUS, 32'h7);
  endtask

  task automatic test_events();
    logic [31:0] obs;
    logic [31:0] e;
    for (int k = 0; k < 3; k++) begin
      event_in = 1'b1; idle();
      event_in = 1'b0; idle();
    end
    exp_q.push_back(32'd3);
    exp_q.push_back(32'h2);
    bus_peek(ADDR_EVT_CNT, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL evt_cnt_3: got %08h want %08h", obs, e);
    end
    bus_peek(ADDR_STATUS, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL evt_status: got %08h want %08h", obs, e);
    end
    // Clear-on-read with an edge in the same cycle.
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    event_in = 1'b1;
    bus_read(ADDR_EVT_CNT, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL cor_first: got %08h want %08h", obs, e);
    end
    event_in = 1'b0;
    bus_read(ADDR_EVT_CNT, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL cor_second: got %08h want %08h", obs, e);
    end
    bus_peek(ADDR_EVT_CNT, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL cor_third: got %08h want %08h", obs, e);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] obs;
    logic [31:0] e;
    // Preload the counter one below saturation instead of 65534 real edges.
    force dut.evt_cnt = 16'hFFFE;
    idle();
    release dut.evt_cnt;
    for (int k = 0; k < 2; k++) begin
      event_in = 1'b1; idle();
      event_in = 1'b0;
      exp_q.push_back(32'h0000_FFFF);
      exp_q.push_back((k == 0) ? 32'h2 : 32'h6);
      bus_peek(ADDR_EVT_CNT, obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL sat_cnt[%0d]: got %08h want %08h", k, obs, e);
      end
      bus_peek(ADDR_STATUS, obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL sat_status[%0d]: got %08h want %08h", k, obs, e);
      end
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] obs;
    logic [31:0] e;
    exp_q.push_back(32'h6);
    exp_q.push_back(32'h4);
    event_in = 1'b1;
    bus_write(ADDR_STATUS, 32'h2);
    event_in = 1'b0;
    bus_peek(ADDR_STATUS, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL w1c_race: got %08h want %08h", obs, e);
    end
    bus_write(ADDR_STATUS, 32'h2);
    bus_peek(ADDR_STATUS, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL w1c_plain: got %08h want %08h", obs, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] a_tab[9];
    logic [31:0] e_tab[9];
    logic [31:0] obs;
    logic [31:0] e;
    bus_write(ADDR_INT_EN, 32'h4);
    bus_write(ADDR_LOAD, 32'd100);
    bus_write(ADDR_CTRL, 32'h1);
    idle(); idle(); idle();
    tests_run++;
    if (s_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_irq: got %b want 1", s_irq);
    end
    #1 PRESETn = 1'b0;
    #1;
    tests_run++;
    if (irq !== 1'b0 || timer_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: irq=%b tick=%b want 0 0", irq, timer_tick);
    end
    a_tab = '{ADDR_CTRL, ADDR_LOAD, ADDR_COUNT, ADDR_STATUS, ADDR_INT_EN,
              ADDR_EVT_CNT, ADDR_SCRATCH, ADDR_ID, 12'h020};
    e_tab = '{32'h0, EXP_LOAD, EXP_LOAD, 32'h0, 32'h0, 32'h0, 32'h0, EXP_ID, 32'h0};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(e_tab[i]);
      raddr = a_tab[i];
      #1;
      obs = rdata;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL mid_reset_read[%03h]: got %08h want %08h", a_tab[i], obs, e);
      end
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    idle(); idle(); idle();
    exp_q.push_back(EXP_LOAD);
    bus_peek(ADDR_COUNT, obs);
    e = exp_q.pop_front();
    tests_run++;
    if (obs !== e || s_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_stopped: count=%08h tick=%b want %08h 0", obs, s_tick, e);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #22 PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    test_reset();
    test_back_to_back();
    test_oneshot();
    test_load_zero();
    test_auto_reload();
    test_events();
    test_saturation();
    test_w1c_race();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
